// File: rtl/sample_serializer_pkg.sv
// Shared constants and state encoding for the sample byte serializer.
package sample_serializer_pkg;

  localparam int unsigned SAMPLE_BYTES = 6;
  localparam int unsigned SAMPLE_W     = 8 * SAMPLE_BYTES;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sample_serializer.sv
// Pops one sample from a show-ahead FIFO and streams it out as BYTES bytes
// on a ready/ack byte interface, counting fully transmitted samples.
module sample_serializer
  import sample_serializer_pkg::*;
#(
  parameter int unsigned BYTES     = SAMPLE_BYTES,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_rdy,
  input  logic [8*BYTES-1:0] sample,
  output logic               sample_ack,
  output logic               data_rdy,
  output logic [7:0]         data,
  input  logic               data_ack,
  output logic               data_last,
  output logic               busy,
  output logic [CNT_W-1:0]   sample_count
);

  localparam int unsigned            IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(BYTES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [8*BYTES-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_last;
  logic [IDX_W-1:0]   sel;

  assign is_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    sample_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_rdy) sample_ack = 1'b1;
      end
      ST_SEND: begin
        if (data_ack) begin
          if (is_last) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (sample_rdy) sample_ack = 1'b1;
            else            state_d    = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pop always (re)loads, covering both the idle start and back-to-back reload.
    if (sample_ack) begin
      hold_d  = sample;
      idx_d   = '0;
      state_d = ST_SEND;
    end
  end

  assign data_rdy     = (state_q == ST_SEND);
  assign busy         = (state_q == ST_SEND);
  assign data_last    = (state_q == ST_SEND) && is_last;
  assign sample_count = cnt_q;
  assign sel          = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);

  always_comb begin
    data = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (sel == IDX_W'(b)) data = hold_q[8*b +: 8];
    end
  end

endmodule
